hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It keeps a 3-entry destination scoreboard of in-flight instructions (EX, MEM, WB) and drives the stall and flush inputs of the fetch and decode pipeline registers. It also generates the EX-stage operand forwarding selects and freezes the whole pipeline while data memory is not ready. It sits beside the decode stage, is fed from decode/control-unit outputs, and is read by fetch, decode, execute and memory stages.

---
 rtl/hazard_pkg.sv | 61 ++++++
 rtl/hazard_scoreboard.sv | 45 ++++
 rtl/hazard_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller:
//               forwarding select encodings, FSM states, scoreboard entry
//               layout and small helpers used by the forwarding logic.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Register index width of the core's register file
    localparam int REG_NUM_SIZE = 5;

    // EX-stage operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Memory-wait controller states
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // One in-flight instruction as tracked by the scoreboard
    typedef struct packed {
        logic                    valid;
        logic [REG_NUM_SIZE-1:0] rd;
        logic [REG_NUM_SIZE-1:0] rs1;
        logic [REG_NUM_SIZE-1:0] rs2;
        logic                    we;
        logic                    load;
        logic                    store;
    } sb_entry_t;

    // An empty slot; bubbles are all-zero so their sources never match a writer
    localparam sb_entry_t SB_BUBBLE = '0;

    // True when the entry will actually update the register file (x0 excluded)
    function automatic logic real_write(input sb_entry_t e);
        return e.valid & e.we & (e.rd != '0);
    endfunction

    // Pick the operand source for one EX source index; the younger MEM result wins
    function automatic logic [1:0] fwd_select(
        input logic [REG_NUM_SIZE-1:0] rs,
        input sb_entry_t               mem_e,
        input sb_entry_t               wb_e
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (real_write(mem_e) && (mem_e.rd == rs)) begin
            sel = FWD_MEM;
        end else if (real_write(wb_e) && (wb_e.rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Three-entry destination scoreboard (EX, MEM, WB) mirroring the
//               in-flight instructions. Shifts one stage per cycle, can hold
//               all entries, and can load a bubble into EX instead of the
//               decode instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_hold,
    input  logic      i_bubble,
    input  sb_entry_t i_dec,
    output sb_entry_t o_ex,
    output sb_entry_t o_mem,
    output sb_entry_t o_wb
);

    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;

    // Advance the shadow pipeline unless frozen; EX takes decode or a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= SB_BUBBLE;
            r_mem <= SB_BUBBLE;
            r_wb  <= SB_BUBBLE;
        end else if (!i_hold) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= i_bubble ? SB_BUBBLE : i_dec;
        end
    end

    assign o_ex  = r_ex;
    assign o_mem = r_mem;
    assign o_wb  = r_wb;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard controller for the 5-stage RISC-V core.
//               Tracks in-flight destinations, resolves load-use and taken
//               branch hazards with stalls/flushes, selects EX operand
//               forwarding sources, and freezes the pipeline while data
//               memory is busy, flagging an over-long wait.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT   = 16,
    parameter int          REG_NUM_SIZE = hazard_pkg::REG_NUM_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_NUM_SIZE-1:0] RS1_D,
    input  logic [REG_NUM_SIZE-1:0] RS2_D,
    input  logic [REG_NUM_SIZE-1:0] RD_D,
    input  logic                    DE_WE_D,
    input  logic                    MEM_REG_D,
    input  logic                    MEM_WE_D,
    input  logic                    BRN_TAKEN_EX,
    input  logic                    MEM_READY,
    output logic                    STALL_F,
    output logic                    STALL_D,
    output logic                    STALL_E,
    output logic                    STALL_M,
    output logic                    FLUSH_F,
    output logic                    FLUSH_D,
    output logic [1:0]              FWD1_EX,
    output logic [1:0]              FWD2_EX,
    output logic                    MEM_TIMEOUT
);

    localparam logic [7:0] c_wait_limit = 8'(WAIT_LIMIT);
    localparam logic [7:0] c_wait_max   = 8'hFF;

    sb_entry_t  w_dec;
    sb_entry_t  w_ex;
    sb_entry_t  w_mem;
    sb_entry_t  w_wb;

    hz_state_t  r_state;
    logic [7:0] r_wait_cnt;
    logic       r_timeout;

    logic       w_mem_access;
    logic       w_mem_stall;
    logic       w_freeze;
    logic       w_branch;
    logic       w_load_use;
    logic       w_bubble;
    logic [7:0] w_wait_cnt_inc;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;
    logic       w_unused_fields;

    // Package the decode-stage fields as the next EX scoreboard entry
    always_comb begin
        w_dec       = SB_BUBBLE;
        w_dec.valid = 1'b1;
        w_dec.rd    = RD_D;
        w_dec.rs1   = RS1_D;
        w_dec.rs2   = RS2_D;
        w_dec.we    = DE_WE_D;
        w_dec.load  = MEM_REG_D;
        w_dec.store = MEM_WE_D;
    end

    hazard_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (w_freeze),
        .i_bubble (w_bubble),
        .i_dec    (w_dec),
        .o_ex     (w_ex),
        .o_mem    (w_mem),
        .o_wb     (w_wb)
    );

    // The MEM entry is a memory access that has not completed this cycle.
    // While waiting the MEM entry is held, so this also covers MEM_WAIT;
    // the state term keeps the freeze tied to the controller explicitly.
    assign w_mem_access = w_mem.valid & (w_mem.load | w_mem.store);
    assign w_mem_stall  = w_mem_access & ~MEM_READY;
    assign w_freeze     = ((r_state == ST_MEM_WAIT) & ~MEM_READY)
                        | ((r_state == ST_RUN) & w_mem_stall);

    // Branch beats load-use; both are ignored while frozen so a branch in EX
    // resolves in the first cycle after the freeze lifts
    assign w_branch   = ~w_freeze & BRN_TAKEN_EX & w_ex.valid;
    assign w_load_use = ~w_freeze & ~w_branch & w_ex.valid & w_ex.load
                      & (w_ex.rd != '0)
                      & ((w_ex.rd == RS1_D) | (w_ex.rd == RS2_D));
    assign w_bubble   = w_branch | w_load_use;

    // Forwarding selects for the instruction currently in EX
    assign w_fwd1 = w_ex.valid ? fwd_select(w_ex.rs1, w_mem, w_wb) : FWD_RF;
    assign w_fwd2 = w_ex.valid ? fwd_select(w_ex.rs2, w_mem, w_wb) : FWD_RF;

    assign w_wait_cnt_inc = (r_wait_cnt == c_wait_max) ? c_wait_max
                                                       : r_wait_cnt + 8'd1;

    // Memory-wait controller: state, saturating wait counter, sticky timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    r_wait_cnt <= w_wait_cnt_inc;
                    if (w_wait_cnt_inc >= c_wait_limit) begin
                        r_timeout <= 1'b1;
                    end
                    if (MEM_READY) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Drive the pipeline controls; everything is forced low during reset
    always_comb begin
        STALL_F     = ~rst & (w_freeze | w_load_use);
        STALL_D     = ~rst & (w_freeze | w_load_use);
        STALL_E     = ~rst & w_freeze;
        STALL_M     = ~rst & w_freeze;
        FLUSH_F     = ~rst & w_branch;
        FLUSH_D     = ~rst & (w_branch | w_load_use);
        FWD1_EX     = rst ? FWD_RF : w_fwd1;
        FWD2_EX     = rst ? FWD_RF : w_fwd2;
        MEM_TIMEOUT = ~rst & r_timeout;
    end

    // Entry fields that no hazard rule looks at in these stages
    assign w_unused_fields = ^{w_ex.we, w_ex.store, w_mem.rs1, w_mem.rs2,
                               w_wb.rs1, w_wb.rs2, w_wb.load, w_wb.store};

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. A behavioural model keeps
//               the in-flight instructions as a small array and derives every
//               expected control from the hazard rules; directed sequences
//               are followed by a long randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int WL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] RS1_D, RS2_D, RD_D;
    logic       DE_WE_D, MEM_REG_D, MEM_WE_D, BRN_TAKEN_EX, MEM_READY;
    logic       STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_F, FLUSH_D;
    logic [1:0] FWD1_EX, FWD2_EX;
    logic       MEM_TIMEOUT;
    logic [10:0] outs;

    always #5 clk = ~clk;

    hazard_unit #(.WAIT_LIMIT(WL), .REG_NUM_SIZE(5)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
        .DE_WE_D(DE_WE_D), .MEM_REG_D(MEM_REG_D), .MEM_WE_D(MEM_WE_D),
        .BRN_TAKEN_EX(BRN_TAKEN_EX), .MEM_READY(MEM_READY),
        .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E), .STALL_M(STALL_M),
        .FLUSH_F(FLUSH_F), .FLUSH_D(FLUSH_D),
        .FWD1_EX(FWD1_EX), .FWD2_EX(FWD2_EX), .MEM_TIMEOUT(MEM_TIMEOUT)
    );

    assign outs = {STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_F, FLUSH_D,
                   FWD1_EX, FWD2_EX, MEM_TIMEOUT};

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int rd;
        int rs1;
        int rs2;
        bit we;
        bit ld;
        bit st;
    } ins_t;

    ins_t pipe[3];          // 0 = EX, 1 = MEM, 2 = WB
    bit   m_waiting;
    int   m_wait_n;
    bit   m_tmo;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes_to(input ins_t e, input int r);
        return e.v && e.we && (e.rd != 0) && (e.rd == r);
    endfunction

    function automatic logic [1:0] src_for(input int r);
        if (writes_to(pipe[1], r)) return 2'b10;
        if (writes_to(pipe[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [10:0] expect_outs();
        bit fz, br, lu;
        logic [1:0] f1, f2;
        if (rst) return '0;
        fz = pipe[1].v && (pipe[1].ld || pipe[1].st) && !MEM_READY;
        br = !fz && BRN_TAKEN_EX && pipe[0].v;
        lu = !fz && !br && pipe[0].v && pipe[0].ld && (pipe[0].rd != 0)
             && ((pipe[0].rd == int'(RS1_D)) || (pipe[0].rd == int'(RS2_D)));
        f1 = pipe[0].v ? src_for(pipe[0].rs1) : 2'b00;
        f2 = pipe[0].v ? src_for(pipe[0].rs2) : 2'b00;
        return {fz | lu, fz | lu, fz, fz, br, br | lu, f1, f2, m_tmo};
    endfunction

    task automatic model_clock(input bit fz, input bit bub);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
            m_waiting = 0;
            m_wait_n  = 0;
            m_tmo     = 0;
            return;
        end
        if (m_waiting) begin
            m_wait_n++;
            if (m_wait_n >= WL) m_tmo = 1;
            if (MEM_READY) m_waiting = 0;
        end else if (fz) begin
            m_waiting = 1;
            m_wait_n  = 0;
        end
        if (!fz) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (bub) pipe[0] = '{default: 0};
            else     pipe[0] = '{v: 1, rd: int'(RD_D), rs1: int'(RS1_D), rs2: int'(RS2_D),
                                 we: DE_WE_D, ld: MEM_REG_D, st: MEM_WE_D};
        end
    endtask

    // Drive one cycle of inputs, compare all outputs against the model, clock.
    task automatic apply(input bit r, input int s1, input int s2, input int d,
                         input bit we, input bit ld, input bit st,
                         input bit br, input bit rdy, output logic [10:0] seen);
        logic [10:0] exp;
        rst = r; RS1_D = 5'(s1); RS2_D = 5'(s2); RD_D = 5'(d);
        DE_WE_D = we; MEM_REG_D = ld; MEM_WE_D = st;
        BRN_TAKEN_EX = br; MEM_READY = rdy;
        #1;
        exp  = expect_outs();
        seen = outs;
        check_eq("outs", 16'(seen), 16'(exp));
        @(posedge clk);
        model_clock(exp[8], exp[5]);
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] s;
        bit r, we, ld, st, br, rdy;
        int s1, s2, d;

        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        m_waiting = 0; m_wait_n = 0; m_tmo = 0;

        // reset
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1, s);
        apply(1, 3, 3, 3, 1, 1, 0, 1, 0, s);
        check_eq("rst_outs", 16'(s), 16'h0);

        // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward
        apply(0, 1, 2, 5, 1, 0, 0, 0, 1, s);
        apply(0, 5, 3, 6, 1, 0, 0, 0, 1, s);
        check_eq("fwd_mem", 16'(FWD1_EX), 16'h2);

        // add x5 ; nop ; sub x6,x5,x3 -> WB forward
        apply(0, 1, 2, 5, 1, 0, 0, 0, 1, s);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, s);
        apply(0, 5, 3, 6, 1, 0, 0, 0, 1, s);
        check_eq("fwd_wb", 16'(FWD1_EX), 16'h1);

        // lw x7 ; add x8,x7,x7 -> one stall, then WB forward on both
        apply(0, 1, 0, 7, 1, 1, 0, 0, 1, s);
        apply(0, 7, 7, 8, 1, 0, 0, 0, 1, s);
        check_eq("lu_stall", 16'(s[10:5]), 16'b110001);
        apply(0, 7, 7, 8, 1, 0, 0, 0, 1, s);
        check_eq("lu_nostall2", 16'(s[10:5]), 16'h0);
        check_eq("lu_fwd", 16'({FWD1_EX, FWD2_EX}), 16'b0101);

        // lw x0 ; reader of x0 -> no stall, no forward
        apply(0, 1, 0, 0, 1, 1, 0, 0, 1, s);
        apply(0, 0, 0, 9, 1, 0, 0, 0, 1, s);
        check_eq("x0_nostall", 16'(s[10:5]), 16'h0);
        check_eq("x0_fwd", 16'({FWD1_EX, FWD2_EX}), 16'h0);

        // branch taken while load-use also present -> branch wins
        apply(0, 1, 0, 7, 1, 1, 0, 0, 1, s);
        apply(0, 7, 7, 8, 1, 0, 0, 1, 1, s);
        check_eq("brn_over_lu", 16'(s[10:5]), 16'b000011);

        // load held in MEM for 3 not-ready cycles, then released
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, s);
        apply(0, 1, 0, 7, 1, 1, 0, 0, 1, s);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, s);
        for (int k = 0; k < 3; k++) begin
            apply(0, 7, 0, 4, 1, 0, 0, 1, 0, s);
            check_eq("wait_stall", 16'({s[10:7], s[6:5]}), 16'b111100);
        end
        apply(0, 7, 0, 4, 1, 0, 0, 0, 1, s);
        check_eq("wait_release", 16'(s[10:7]), 16'h0);
        check_eq("timeout_set", 16'(MEM_TIMEOUT), 16'h1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, s);
        check_eq("timeout_sticky", 16'(MEM_TIMEOUT), 16'h1);

        // reset asserted in the middle of a memory wait
        apply(0, 1, 0, 7, 1, 1, 0, 0, 1, s);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, s);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, s);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, s);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, s);
        check_eq("rst_mid_wait", 16'(s), 16'h0);
        check_eq("rst_clr_tmo", 16'(MEM_TIMEOUT), 16'h0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, s);
        check_eq("run_after_rst", 16'(s[10:7]), 16'h0);

        // randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            s1  = $urandom_range(0, 3);
            s2  = $urandom_range(0, 3);
            d   = $urandom_range(0, 3);
            we  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 3) == 0);
            st  = !ld && ($urandom_range(0, 4) == 0);
            br  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            apply(r, s1, s2, d, we, ld, st, br, rdy, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
